// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response signals between the ALU share arbiter and its environment.
interface alu_share_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 4
);
   logic                  a_valid;
   logic                  a_ready;
   logic [DATA_WIDTH-1:0] a_in1;
   logic [DATA_WIDTH-1:0] a_in2;
   logic [OP_WIDTH-1:0]   a_op;
   logic                  b_valid;
   logic                  b_ready;
   logic [DATA_WIDTH-1:0] b_in1;
   logic [DATA_WIDTH-1:0] b_in2;
   logic [OP_WIDTH-1:0]   b_op;
   logic [DATA_WIDTH-1:0] alu_in1;
   logic [DATA_WIDTH-1:0] alu_in2;
   logic [OP_WIDTH-1:0]   alu_op;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_zero;
   logic                  alu_lt;
   logic                  alu_gt;
   logic                  rsp_valid_a;
   logic                  rsp_valid_b;
   logic                  rsp_ready_a;
   logic                  rsp_ready_b;
   logic [DATA_WIDTH-1:0] rsp_result;
   logic                  rsp_zero;
   logic                  rsp_lt;
   logic                  rsp_gt;
   logic                  busy;

   // Arbiter side
   modport slave (
      input  a_valid, a_in1, a_in2, a_op,
      input  b_valid, b_in1, b_in2, b_op,
      input  alu_result, alu_zero, alu_lt, alu_gt,
      input  rsp_ready_a, rsp_ready_b,
      output a_ready, b_ready,
      output alu_in1, alu_in2, alu_op,
      output rsp_valid_a, rsp_valid_b, rsp_result, rsp_zero, rsp_lt, rsp_gt,
      output busy
   );

   // Requesters and ALU side
   modport master (
      output a_valid, a_in1, a_in2, a_op,
      output b_valid, b_in1, b_in2, b_op,
      output alu_result, alu_zero, alu_lt, alu_gt,
      output rsp_ready_a, rsp_ready_b,
      input  a_ready, b_ready,
      input  alu_in1, alu_in2, alu_op,
      input  rsp_valid_a, rsp_valid_b, rsp_result, rsp_zero, rsp_lt, rsp_gt,
      input  busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// one operation in flight, registered operands and registered response.
module alu_share_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_share_arbiter_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   state_t                state_q, state_d;
   logic                  prio_q, prio_d;
   logic                  owner_q, owner_d;
   logic [DATA_WIDTH-1:0] alu_in1_q, alu_in1_d;
   logic [DATA_WIDTH-1:0] alu_in2_q, alu_in2_d;
   logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
   logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                  rsp_zero_q, rsp_zero_d;
   logic                  rsp_lt_q, rsp_lt_d;
   logic                  rsp_gt_q, rsp_gt_d;
   logic                  rsp_valid_a_q, rsp_valid_a_d;
   logic                  rsp_valid_b_q, rsp_valid_b_d;
   logic                  grant_a_c, grant_b_c;
   logic                  a_ready_c, b_ready_c;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         prio_q        <= PORT_A;
         owner_q       <= PORT_A;
         alu_in1_q     <= '0;
         alu_in2_q     <= '0;
         alu_op_q      <= '0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_lt_q      <= 1'b0;
         rsp_gt_q      <= 1'b0;
         rsp_valid_a_q <= 1'b0;
         rsp_valid_b_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         owner_q       <= owner_d;
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         alu_op_q      <= alu_op_d;
         rsp_result_q  <= rsp_result_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_lt_q      <= rsp_lt_d;
         rsp_gt_q      <= rsp_gt_d;
         rsp_valid_a_q <= rsp_valid_a_d;
         rsp_valid_b_q <= rsp_valid_b_d;
      end
   end

   // Grant, next state and next register values
   always_comb begin
      state_d       = state_q;
      prio_d        = prio_q;
      owner_d       = owner_q;
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      alu_op_d      = alu_op_q;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_lt_d      = rsp_lt_q;
      rsp_gt_d      = rsp_gt_q;
      rsp_valid_a_d = rsp_valid_a_q;
      rsp_valid_b_d = rsp_valid_b_q;
      a_ready_c     = 1'b0;
      b_ready_c     = 1'b0;
      grant_a_c     = bus.a_valid && (!bus.b_valid || (prio_q == PORT_A));
      grant_b_c     = bus.b_valid && !grant_a_c;

      unique case (state_q)
         IDLE: begin
            a_ready_c = grant_a_c;
            b_ready_c = grant_b_c;
            if (grant_a_c) begin
               alu_in1_d = bus.a_in1;
               alu_in2_d = bus.a_in2;
               alu_op_d  = bus.a_op;
               owner_d   = PORT_A;
               prio_d    = PORT_B;
               state_d   = EXEC;
            end else if (grant_b_c) begin
               alu_in1_d = bus.b_in1;
               alu_in2_d = bus.b_in2;
               alu_op_d  = bus.b_op;
               owner_d   = PORT_B;
               prio_d    = PORT_A;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d  = bus.alu_result;
            rsp_zero_d    = bus.alu_zero;
            rsp_lt_d      = bus.alu_lt;
            rsp_gt_d      = bus.alu_gt;
            rsp_valid_a_d = (owner_q == PORT_A);
            rsp_valid_b_d = (owner_q == PORT_B);
            state_d       = RESP;
         end
         RESP: begin
            // Only the owner's response ready can retire the operation
            if ((owner_q == PORT_A) ? bus.rsp_ready_a : bus.rsp_ready_b) begin
               rsp_valid_a_d = 1'b0;
               rsp_valid_b_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.a_ready     = a_ready_c;
   assign bus.b_ready     = b_ready_c;
   assign bus.alu_in1     = alu_in1_q;
   assign bus.alu_in2     = alu_in2_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.rsp_valid_a = rsp_valid_a_q;
   assign bus.rsp_valid_b = rsp_valid_b_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_zero    = rsp_zero_q;
   assign bus.rsp_lt      = rsp_lt_q;
   assign bus.rsp_gt      = rsp_gt_q;
   assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned OW = 4;

   logic clk = 1'b0;
   logic reset;

   alu_share_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

   alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Team ALU: op 1 subtracts, every other code adds; flags compare operands unsigned
   function automatic logic [DW+2:0] alu_f(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic [OW-1:0] op);
      logic [DW-1:0] r;
      r = (op == 4'd1) ? x - y : x + y;
      return {x > y, x < y, r == '0, r};
   endfunction

   always_comb {bus.alu_gt, bus.alu_lt, bus.alu_zero, bus.alu_result} =
      alu_f(bus.alu_in1, bus.alu_in2, bus.alu_op);

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one operation at a time, response two edges after accept
   bit            m_free, m_exec, m_rv, m_owner, m_prio;
   logic [DW-1:0] m_in1, m_in2;
   logic [OW-1:0] m_op;
   logic [DW+2:0] m_res;
   bit            acc_a, acc_b, keep_valid;

   task automatic model_reset();
      m_free = 1; m_exec = 0; m_rv = 0; m_owner = 0; m_prio = 0;
      m_in1 = '0; m_in2 = '0; m_op = '0; m_res = '0;
   endtask

   task automatic check_outputs();
      bit ga, gb;
      ga = m_free && bus.a_valid && (!bus.b_valid || !m_prio);
      gb = m_free && bus.b_valid && !ga;
      chk("a_ready", 64'(bus.a_ready), 64'(ga));
      chk("b_ready", 64'(bus.b_ready), 64'(gb));
      chk("busy", 64'(bus.busy), 64'(!m_free));
      chk("rsp_valid_a", 64'(bus.rsp_valid_a), 64'(m_rv && !m_owner));
      chk("rsp_valid_b", 64'(bus.rsp_valid_b), 64'(m_rv && m_owner));
      chk("alu_in1", 64'(bus.alu_in1), 64'(m_in1));
      chk("alu_in2", 64'(bus.alu_in2), 64'(m_in2));
      chk("alu_op", 64'(bus.alu_op), 64'(m_op));
      chk("rsp_result", 64'(bus.rsp_result), 64'(m_res[DW-1:0]));
      chk("rsp_flags", 64'({bus.rsp_gt, bus.rsp_lt, bus.rsp_zero}), 64'(m_res[DW+2:DW]));
   endtask

   // Check at the falling edge, advance the model over the next rising edge
   task automatic step();
      @(negedge clk);
      check_outputs();
      acc_a = m_free && bus.a_valid && (!bus.b_valid || !m_prio);
      acc_b = m_free && bus.b_valid && !acc_a;
      if (acc_a || acc_b) begin
         m_in1   = acc_a ? bus.a_in1 : bus.b_in1;
         m_in2   = acc_a ? bus.a_in2 : bus.b_in2;
         m_op    = acc_a ? bus.a_op  : bus.b_op;
         m_owner = acc_b;
         m_prio  = acc_a;
         m_free  = 0;
         m_exec  = 1;
      end else if (m_exec) begin
         m_res  = alu_f(m_in1, m_in2, m_op);
         m_rv   = 1;
         m_exec = 0;
      end else if (m_rv && (m_owner ? bus.rsp_ready_b : bus.rsp_ready_a)) begin
         m_rv   = 0;
         m_free = 1;
      end
      @(posedge clk);
      #1;
      if (acc_a && !keep_valid) bus.a_valid = 1'b0;
      if (acc_b && !keep_valid) bus.b_valid = 1'b0;
   endtask

   task automatic req_a(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [OW-1:0] op);
      bus.a_valid = 1'b1; bus.a_in1 = x; bus.a_in2 = y; bus.a_op = op;
   endtask

   task automatic req_b(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [OW-1:0] op);
      bus.b_valid = 1'b1; bus.b_in1 = x; bus.b_in2 = y; bus.b_op = op;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bus.a_valid = 0; bus.a_in1 = '0; bus.a_in2 = '0; bus.a_op = '0;
      bus.b_valid = 0; bus.b_in1 = '0; bus.b_in2 = '0; bus.b_op = '0;
      bus.rsp_ready_a = 1; bus.rsp_ready_b = 1;
      keep_valid = 0;
      do_reset();
      step();

      // Single A subtraction, then B with equal operands
      req_a(32'd5, 32'd3, 4'b0001);
      repeat (4) step();
      req_b(32'd7, 32'd7, 4'b0001);
      repeat (4) step();

      // Contention from reset: grants alternate
      do_reset();
      keep_valid = 1;
      req_a(32'd10, 32'd20, 4'b0000);
      req_b(32'd100, 32'd200, 4'b0000);
      repeat (10) step();
      keep_valid = 0;
      bus.a_valid = 0; bus.b_valid = 0;
      repeat (3) step();

      // Reset while in EXEC discards the operation
      req_a(32'd9, 32'd4, 4'b0000);
      while (!acc_a) step();
      #2 reset = 1'b1;
      bus.a_valid = 0;
      #1 model_reset();
      check_outputs();
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) step();
      req_a(32'd1, 32'd2, 4'b0000);
      repeat (4) step();

      // Response backpressure on A with B pending
      bus.rsp_ready_a = 0;
      req_a(32'd50, 32'd8, 4'b0001);
      req_b(32'd6, 32'd6, 4'b0000);
      repeat (7) step();
      bus.rsp_ready_a = 1;
      repeat (6) step();

      // Undefined opcode passes through to the ALU
      req_a(32'hFFFF_FFFF, 32'd1, 4'b1111);
      repeat (4) step();

      // Randomized traffic with valid held until accepted
      for (int c = 0; c < 400; c++) begin
         if (!bus.a_valid) begin
            bus.a_valid = 1'($urandom_range(0, 1));
            bus.a_in1 = $urandom; bus.a_in2 = $urandom;
            bus.a_op = OW'($urandom_range(0, 15));
         end
         if (!bus.b_valid) begin
            bus.b_valid = 1'($urandom_range(0, 1));
            bus.b_in1 = $urandom; bus.b_in2 = $urandom;
            bus.b_op = OW'($urandom_range(0, 15));
         end
         bus.rsp_ready_a = ($urandom_range(0, 3) != 0);
         bus.rsp_ready_b = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
